encoder_16x4_serial: RTL and testbench
======================================

# encoder_16x4_serial

Sequential 16-to-4 encoder that accepts a 16-bit request vector and emits the 4-bit index of every set bit, lowest index first, one index per output handshake. It is the encoding side of the 4:16 decoder path: a one-hot vector gives one beat, and a multi-hot vector is serialized rather than collapsed. It sits between request-collecting logic upstream and any index consumer downstream, with valid/ready on both sides.

## Interface
- Parameters: none. Vector width is fixed at 16 and index width at 4.
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream presents in_vec.
- in_ready  out  1  block can accept a vector.
- in_vec  in  16  request vector; bit i requests index i.
- out_valid  out  1  out_idx/out_last valid.
- out_ready  in  1  downstream accepts current index.
- out_idx  out  4  index of lowest pending set bit.
- out_last  out  1  current index is the final one of this vector.
- remaining  out  5  count of set bits still pending, including the current one (0..16).
- empty_pulse  out  1  one-cycle pulse after an all-zero vector is accepted.

## Operation
- State: FSM {IDLE, BUSY}, 16-bit pending register, 5-bit remaining counter, empty_pulse flop.
- IDLE:
  - in_ready=1, out_valid=0.
  - Input accept = in_valid && in_ready.
  - Accept with in_vec==0: stay IDLE, set empty_pulse for the next cycle only.
  - Accept with in_vec!=0: pending<=in_vec, remaining<=popcount(in_vec), go BUSY.
- BUSY:
  - in_ready=0. in_valid is ignored and in_vec is not sampled.
  - out_valid=1.
  - out_idx = position of the lowest set bit of pending.
  - out_last = (remaining==1).
  - Output handshake = out_valid && out_ready: clear that bit in pending and decrement remaining.
  - If out_last on a handshake: go IDLE. pending becomes 0.
- out_idx, out_last and remaining depend only on registered state, never on in_* or out_ready. They stay stable while out_valid=1 and out_ready=0.
- In IDLE: out_idx=0, out_last=0, remaining=0.
- Reset: takes priority over all events, including a simultaneous accept or handshake.
  - State IDLE, pending=0, remaining=0, empty_pulse=0.
  - Outputs in the first cycle after the reset edge: in_ready=1, out_valid=0, out_idx=0, out_last=0, remaining=0.
  - Reset mid-vector discards all pending indices with no further output.

## Timing
- Vector accepted at edge N → out_valid=1 in cycle N+1, showing the first index.
- With out_ready held high: one index per cycle. A vector with k set bits occupies cycles N+1..N+k.
- Final handshake at edge M → in_ready=1 in cycle M+1. There is one dead cycle between vectors, with no accept/output overlap.
- Zero vector accepted at edge N → empty_pulse=1 in cycle N+1 only. in_ready stays 1, so back-to-back zero vectors are accepted every cycle.
- Worst case 16'hFFFF: 16 output beats, remaining counts 16 down to 1.
- No combinational path from any input to any output.

## Test plan
- Reset, then in_vec=16'h0001 with out_ready=1 → cycle after accept: out_idx=0, out_last=1, remaining=1. The following cycle: out_valid=0, in_ready=1.
- in_vec=16'h8421 with out_ready=1 → consecutive beats with idx 0,5,10,15 and remaining 4,3,2,1. out_last=1 only on idx 15.
- in_vec=16'h0003 with out_ready=0 for 3 cycles → idx 0 held with remaining=2 for all three cycles. After out_ready rises: idx 0, then idx 1 with out_last=1.
- in_vec=16'h0000 accepted → empty_pulse=1 for exactly one cycle, out_valid never asserts, in_ready stays 1.
- in_vec=16'hFFFF, out_ready=1, rst asserted after beat idx 4 → next cycle: out_valid=0, remaining=0, in_ready=1. Then in_vec=16'h0100 → single beat idx 8, out_last=1.
- During BUSY on 16'h0030, drive in_valid=1 with in_vec=16'hFFFF → in_ready=0, that vector is not accepted, and the output sequence is exactly idx 4 then 5.

Source files
------------

// File: rtl/encoder_16x4_serial.sv
// Serializing 16-to-4 encoder: accepts a request vector and emits the index of every
// set bit, lowest first, one per output handshake.
module encoder_16x4_serial (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_vec,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic [4:0]  remaining,
  output logic        empty_pulse
);

  typedef enum logic [0:0] {StIdle, StBusy} state_e;

  state_e      state_q, state_d;
  logic [15:0] pending_q, pending_d;
  logic [4:0]  remaining_q, remaining_d;
  logic        empty_pulse_q, empty_pulse_d;

  function automatic logic [4:0] popcount16(input logic [15:0] v);
    logic [4:0] c;
    c = '0;
    for (int i = 0; i < 16; i++) begin
      c = c + 5'(v[i]);
    end
    return c;
  endfunction

  // Scan from the top so the lowest set bit wins.
  function automatic logic [3:0] lowest_set(input logic [15:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 15; i >= 0; i--) begin
      if (v[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

  always_comb begin
    state_d       = state_q;
    pending_d     = pending_q;
    remaining_d   = remaining_q;
    empty_pulse_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          if (in_vec == 16'h0000) begin
            empty_pulse_d = 1'b1;
          end else begin
            pending_d   = in_vec;
            remaining_d = popcount16(in_vec);
            state_d     = StBusy;
          end
        end
      end
      StBusy: begin
        if (out_ready) begin
          // Clearing the lowest set bit retires the index currently on out_idx.
          pending_d   = pending_q & (pending_q - 16'd1);
          remaining_d = remaining_q - 5'd1;
          if (remaining_q == 5'd1) begin
            pending_d = '0;
            state_d   = StIdle;
          end
        end
      end
      default: begin
        state_d     = StIdle;
        pending_d   = '0;
        remaining_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= StIdle;
      pending_q     <= '0;
      remaining_q   <= '0;
      empty_pulse_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      pending_q     <= pending_d;
      remaining_q   <= remaining_d;
      empty_pulse_q <= empty_pulse_d;
    end
  end

  always_comb begin
    in_ready    = (state_q == StIdle);
    out_valid   = (state_q == StBusy);
    out_idx     = (state_q == StBusy) ? lowest_set(pending_q) : 4'd0;
    out_last    = (state_q == StBusy) && (remaining_q == 5'd1);
    remaining   = remaining_q;
    empty_pulse = empty_pulse_q;
  end

endmodule

// File: tb/tb_encoder_16x4_serial.sv
// Scoreboard bench for encoder_16x4_serial: directed vectors push expected beats,
// a monitor pops and compares on every output handshake.
module tb_encoder_16x4_serial;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_vec;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  out_idx;
  logic        out_last;
  logic [4:0]  remaining;
  logic        empty_pulse;

  int checks = 0;
  int errors = 0;

  // Expected beat packed as {idx, last, remaining}.
  logic [9:0] exp_q[$];

  encoder_16x4_serial dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_vec      (in_vec),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_last    (out_last),
    .remaining   (remaining),
    .empty_pulse (empty_pulse)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic push(input logic [3:0] idx, input logic last, input logic [4:0] rem);
    exp_q.push_back({idx, last, rem});
  endtask

  // Monitor: every handshake outside reset must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_beat: got idx %0d last %0b rem %0d expected none",
                 out_idx, out_last, remaining);
      end else begin
        logic [9:0] e;
        e = exp_q.pop_front();
        check("beat_idx", 16'(out_idx), 16'(e[9:6]));
        check("beat_last", 16'(out_last), 16'(e[5]));
        check("beat_remaining", 16'(remaining), 16'(e[4:0]));
      end
    end
  end

  task automatic accept(input logic [15:0] v);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = v;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = '0;
  endtask

  task automatic drain(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #2;
      if (exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_drain: got %0d beats left expected 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    check({name, "_in_ready"}, 16'(in_ready), 16'd1);
    check({name, "_out_valid"}, 16'(out_valid), 16'd0);
    check({name, "_out_idx"}, 16'(out_idx), 16'd0);
    check({name, "_out_last"}, 16'(out_last), 16'd0);
    check({name, "_remaining"}, 16'(remaining), 16'd0);
  endtask

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    check_idle("reset");
    check("reset_empty_pulse", 16'(empty_pulse), 16'd0);

    // One-hot vector: single beat, then idle.
    push(4'd0, 1'b1, 5'd1);
    accept(16'h0001);
    drain("onehot");
    check_idle("onehot_after");

    // Multi-hot vector serialized lowest first.
    push(4'd0, 1'b0, 5'd4);
    push(4'd5, 1'b0, 5'd3);
    push(4'd10, 1'b0, 5'd2);
    push(4'd15, 1'b1, 5'd1);
    accept(16'h8421);
    drain("h8421");
    check_idle("h8421_after");

    // Backpressure: output holds while out_ready is low.
    out_ready = 1'b0;
    push(4'd0, 1'b0, 5'd2);
    push(4'd1, 1'b1, 5'd1);
    accept(16'h0003);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("hold_valid", 16'(out_valid), 16'd1);
      check("hold_idx", 16'(out_idx), 16'd0);
      check("hold_remaining", 16'(remaining), 16'd2);
      check("hold_last", 16'(out_last), 16'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    drain("h0003");
    check_idle("h0003_after");

    // Zero vector: one-cycle empty pulse, no output, back-to-back accepted.
    accept(16'h0000);
    @(negedge clk);
    check("zero_pulse", 16'(empty_pulse), 16'd1);
    check("zero_in_ready", 16'(in_ready), 16'd1);
    check("zero_out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("zero_pulse_clear", 16'(empty_pulse), 16'd0);
    @(posedge clk); #1;
    in_valid = 1'b1;
    in_vec   = 16'h0000;
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_zero_pulse1", 16'(empty_pulse), 16'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    check("b2b_zero_pulse2", 16'(empty_pulse), 16'd1);
    check("b2b_zero_out_valid", 16'(out_valid), 16'd0);
    @(negedge clk);
    check("b2b_zero_pulse_clear", 16'(empty_pulse), 16'd0);

    // Reset mid-vector after beat idx 4 discards the rest.
    for (int i = 0; i < 5; i++) begin
      push(4'(i), 1'b0, 5'(16 - i));
    end
    accept(16'hFFFF);
    repeat (4) @(posedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_idle("midreset");
    check("midreset_beats_left", 16'(exp_q.size()), 16'd0);
    exp_q.delete();
    push(4'd8, 1'b1, 5'd1);
    accept(16'h0100);
    drain("h0100");
    check_idle("h0100_after");

    // in_valid during BUSY is ignored.
    push(4'd4, 1'b0, 5'd2);
    push(4'd5, 1'b1, 5'd1);
    accept(16'h0030);
    in_valid = 1'b1;
    in_vec   = 16'hFFFF;
    @(negedge clk);
    check("busy_in_ready", 16'(in_ready), 16'd0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_vec   = '0;
    drain("h0030");
    check_idle("h0030_after");
    repeat (3) @(posedge clk);
    check("h0030_no_extra", 16'(exp_q.size()), 16'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
